// File: rtl/video_pkg.sv
// Shared video-stage constants and helpers.
// Holds the default visible-area dimensions, the bus widths used by the pixel
// pipeline and the colour constants. next_color() gives the ball colour
// sequence 1..7, wrapping back to 1, so it never returns black.
package video_pkg;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned RGB_W     = 3;
    localparam int unsigned POS_W     = 10;

    localparam logic [RGB_W-1:0] RGB_BLACK = 3'b000;
    localparam logic [RGB_W-1:0] RGB_WHITE = 3'b111;

    // Next ball colour: 1..7, with 7 followed by 1.
    function automatic logic [RGB_W-1:0] next_color(input logic [RGB_W-1:0] c);
        return (c == RGB_WHITE) ? RGB_W'(1) : RGB_W'(c + RGB_W'(1));
    endfunction

endpackage

// File: rtl/ball_axis.sv
// One axis of ball motion: position register, direction bit and clamp/flip.
// Ports:
//   clk, reset   pixel clock, synchronous active-high reset
//   step_i       frame strobe; the position advances by SPEED when it is high
//   pos_o        current top-left coordinate on this axis
//   flip_c       high in a step cycle whose update reverses the direction
module ball_axis
    import video_pkg::*;
#(
    parameter int unsigned EXTENT = 640,
    parameter int unsigned SIZE   = 8,
    parameter int unsigned INIT   = 128,
    parameter int unsigned SPEED  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_i,
    output logic [POS_W-1:0] pos_o,
    output logic             flip_c
);

    localparam int unsigned EXT_W = POS_W + 1;
    localparam logic [EXT_W-1:0] MAX_X   = EXT_W'(EXTENT - SIZE);
    localparam logic [EXT_W-1:0] SPEED_X = EXT_W'(SPEED);

    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;     // 0: increasing, 1: decreasing
    logic [EXT_W-1:0] pos_ext;

    // One extra bit of headroom so that pos + SPEED cannot wrap.
    assign pos_ext = {1'b0, pos_q};

    // Next position: advance, or clamp to the edge and reverse.
    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        flip_c = 1'b0;
        if (step_i) begin
            if (!dir_q) begin
                if (pos_ext + SPEED_X >= MAX_X) begin
                    pos_d  = POS_W'(MAX_X);
                    dir_d  = 1'b1;
                    flip_c = 1'b1;
                end else begin
                    pos_d = POS_W'(pos_ext + SPEED_X);
                end
            end else begin
                if (pos_ext <= SPEED_X) begin
                    pos_d  = '0;
                    dir_d  = 1'b0;
                    flip_c = 1'b1;
                end else begin
                    pos_d = POS_W'(pos_ext - SPEED_X);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= POS_W'(INIT);
            dir_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/ball_renderer.sv
// Pixel-stage renderer for one square ball bouncing around the visible area.
// Optional feature: define BALL_COLOR_CYCLE_EN to step the ball colour on each
// bounce (1..7, never black); otherwise the ball is always white.
// Ports:
//   clk, reset         pixel clock, synchronous active-high reset
//   hpos, vpos         beam position from the sync generator
//   display_on         high inside the visible area
//   hsync, vsync       raw syncs, delayed by one cycle onto hsync_o/vsync_o
//   bg_rgb             background colour, aligned with hpos
//   rgb                registered pixel colour {b,g,r}
//   bounce             one-cycle pulse after a frame update that reversed an axis
module ball_renderer
    import video_pkg::*;
#(
    parameter int unsigned H_DISPLAY = video_pkg::H_DISPLAY,
    parameter int unsigned V_DISPLAY = video_pkg::V_DISPLAY,
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned INIT_X    = 128,
    parameter int unsigned INIT_Y    = 128,
    parameter int unsigned SPEED     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] vpos,
    input  logic             display_on,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [RGB_W-1:0] bg_rgb,
    output logic [RGB_W-1:0] rgb,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             bounce
);

    localparam int unsigned EXT_W = POS_W + 1;
    localparam logic [EXT_W-1:0] SIZE_X = EXT_W'(BALL_SIZE);

    logic             strobe_c;
    logic             flip_x_c, flip_y_c;
    logic [POS_W-1:0] ball_x, ball_y;
    logic [RGB_W-1:0] ball_rgb;
    logic             hit_c;
    logic [EXT_W-1:0] hx, vy, bx, by;

    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             hsync_q, vsync_q;
    logic             bounce_q, bounce_d;

    // First blanking line, column 0: exactly once per frame.
    assign strobe_c = (hpos == POS_W'(0)) && (vpos == POS_W'(V_DISPLAY));

    ball_axis #(
        .EXTENT (H_DISPLAY),
        .SIZE   (BALL_SIZE),
        .INIT   (INIT_X),
        .SPEED  (SPEED)
    ) u_axis_x (
        .clk    (clk),
        .reset  (reset),
        .step_i (strobe_c),
        .pos_o  (ball_x),
        .flip_c (flip_x_c)
    );

    ball_axis #(
        .EXTENT (V_DISPLAY),
        .SIZE   (BALL_SIZE),
        .INIT   (INIT_Y),
        .SPEED  (SPEED)
    ) u_axis_y (
        .clk    (clk),
        .reset  (reset),
        .step_i (strobe_c),
        .pos_o  (ball_y),
        .flip_c (flip_y_c)
    );

`ifdef BALL_COLOR_CYCLE_EN
    logic [RGB_W-1:0] ball_rgb_q, ball_rgb_d;

    // A corner hit flips both axes but advances the colour only once.
    always_comb begin
        ball_rgb_d = ball_rgb_q;
        if (flip_x_c || flip_y_c) begin
            ball_rgb_d = next_color(ball_rgb_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ball_rgb_q <= RGB_WHITE;
        end else begin
            ball_rgb_q <= ball_rgb_d;
        end
    end

    assign ball_rgb = ball_rgb_q;
`else
    assign ball_rgb = RGB_WHITE;
`endif

    // Hit compare in 11 bits so ball_x + BALL_SIZE cannot wrap.
    assign hx    = {1'b0, hpos};
    assign vy    = {1'b0, vpos};
    assign bx    = {1'b0, ball_x};
    assign by    = {1'b0, ball_y};
    assign hit_c = (hx >= bx) && (hx < bx + SIZE_X) &&
                   (vy >= by) && (vy < by + SIZE_X);

    // Pixel mux and bounce pulse.
    always_comb begin
        rgb_d    = RGB_BLACK;
        bounce_d = flip_x_c || flip_y_c;
        if (display_on) begin
            rgb_d = hit_c ? ball_rgb : bg_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q    <= RGB_BLACK;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bounce_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            hsync_q  <= hsync;
            vsync_q  <= vsync;
            bounce_q <= bounce_d;
        end
    end

    assign rgb     = rgb_q;
    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q;
    assign bounce  = bounce_q;

endmodule
